// File: rtl/stream_video_input_fifo_pkg.sv
// rtl/stream_video_input_fifo_pkg.sv - shared video beat type, pixel width and pointer-width helper
package stream_video_input_fifo_pkg;

  localparam int PIXEL_WIDTH = 24;

  // One stored beat: start-of-frame, end-of-line, pixel
  typedef struct packed {
    logic                   tuser;
    logic                   tlast;
    logic [PIXEL_WIDTH-1:0] tdata;
  } video_beat_t;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } sync_state_t;

  // Pointer width: index bits plus one wrap bit
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/video_fifo_mem.sv
// rtl/video_fifo_mem.sv - simple dual-port memory, synchronous write and registered read
module video_fifo_mem
  import stream_video_input_fifo_pkg::*;
#(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register doubles as the output stage; it only moves on rd_en so data holds under stall
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/stream_video_input_fifo.sv
// rtl/stream_video_input_fifo.sv - elastic video beat FIFO with FWFT output; FRAME_SYNC_EN adds frame re-sync
module stream_video_input_fifo
  import stream_video_input_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = PIXEL_WIDTH,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = DEPTH - 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       s_axis_video_tdata,
  input  logic                        s_axis_video_tvalid,
  output logic                        s_axis_video_tready,
  input  logic                        s_axis_video_tuser,
  input  logic                        s_axis_video_tlast,
  output logic [DATA_WIDTH-1:0]       m_axis_video_tdata,
  output logic                        m_axis_video_tvalid,
  input  logic                        m_axis_video_tready,
  output logic                        m_axis_video_tuser,
  output logic                        m_axis_video_tlast,
  output logic [ptr_width(DEPTH)-1:0] level,
  output logic                        almost_full,
  output logic                        frame_err
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] AFULL_THR = PW'(AFULL_LEVEL);

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt, level_q;
  logic          s_ready_q, m_valid_q, last_tlast_q, frame_err_q, afull_q;
  logic          accept, mem_empty, full_nxt, load, mem_wr, sync_pass, in_run, err_det;
  logic [EW-1:0] rd_entry;

  // Ready comes from a register only, so a same-cycle read never frees a slot for a write
  assign accept    = s_axis_video_tvalid && s_ready_q;
  assign mem_empty = (wr_ptr == rd_ptr);
  assign load      = !mem_empty && (!m_valid_q || m_axis_video_tready);
  assign mem_wr    = accept && sync_pass;
  assign err_det   = accept && s_axis_video_tuser && !last_tlast_q && in_run;

`ifdef FRAME_SYNC_EN
  sync_state_t state;

  // Discard beats until the first start-of-frame after reset, then run normally
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_SYNC;
    end else if (state == ST_SYNC && accept && s_axis_video_tuser) begin
      state <= ST_RUN;
    end
  end

  assign in_run    = (state == ST_RUN);
  assign sync_pass = in_run || s_axis_video_tuser;
`else
  assign in_run    = 1'b1;
  assign sync_pass = 1'b1;
`endif

  // Next pointer values, occupancy and full detection via the wrap bit
  always_comb begin
    wr_ptr_nxt = mem_wr ? wr_ptr + PTR_ONE : wr_ptr;
    rd_ptr_nxt = load ? rd_ptr + PTR_ONE : rd_ptr;
    level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    full_nxt   = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) && (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
  end

  // Pointers, registered level/almost_full and input ready
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      afull_q   <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      level_q   <= level_nxt;
      afull_q   <= (level_nxt >= AFULL_THR);
      s_ready_q <= !full_nxt;
    end
  end

  // Output register valid: set on load, cleared when consumed with nothing to replace it
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_valid_q <= 1'b0;
    end else if (load) begin
      m_valid_q <= 1'b1;
    end else if (m_axis_video_tready) begin
      m_valid_q <= 1'b0;
    end
  end

  // Track end-of-line of the previous accepted beat; a start-of-frame mid-line is an error
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_tlast_q <= 1'b1;
      frame_err_q  <= 1'b0;
    end else begin
      frame_err_q <= err_det;
      if (accept) begin
        last_tlast_q <= s_axis_video_tlast;
      end
    end
  end

  video_fifo_mem #(
    .WIDTH(EW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (mem_wr),
    .wr_addr(wr_ptr[AW-1:0]),
    .wr_data({s_axis_video_tuser, s_axis_video_tlast, s_axis_video_tdata}),
    .rd_en  (load),
    .rd_addr(rd_ptr[AW-1:0]),
    .rd_data(rd_entry)
  );

  assign s_axis_video_tready = s_ready_q;
  assign m_axis_video_tvalid = m_valid_q;
  assign m_axis_video_tdata  = rd_entry[DATA_WIDTH-1:0];
  assign m_axis_video_tlast  = rd_entry[DATA_WIDTH];
  assign m_axis_video_tuser  = rd_entry[DATA_WIDTH+1];
  assign level               = level_q;
  assign almost_full         = afull_q;
  assign frame_err           = frame_err_q;

endmodule

// File: tb/tb_stream_video_input_fifo.sv
// tb/tb_stream_video_input_fifo.sv - scoreboard bench for stream_video_input_fifo
module tb_stream_video_input_fifo;

  localparam int DW    = 24;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef logic [DW+1:0] beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] s_axis_video_tdata = '0;
  logic          s_axis_video_tvalid = 1'b0;
  logic          s_axis_video_tready;
  logic          s_axis_video_tuser = 1'b0;
  logic          s_axis_video_tlast = 1'b0;
  logic [DW-1:0] m_axis_video_tdata;
  logic          m_axis_video_tvalid;
  logic          m_axis_video_tready = 1'b0;
  logic          m_axis_video_tuser;
  logic          m_axis_video_tlast;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          frame_err;

  stream_video_input_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AFULL_LEVEL(DEPTH - 4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .s_axis_video_tdata (s_axis_video_tdata),
    .s_axis_video_tvalid(s_axis_video_tvalid),
    .s_axis_video_tready(s_axis_video_tready),
    .s_axis_video_tuser (s_axis_video_tuser),
    .s_axis_video_tlast (s_axis_video_tlast),
    .m_axis_video_tdata (m_axis_video_tdata),
    .m_axis_video_tvalid(m_axis_video_tvalid),
    .m_axis_video_tready(m_axis_video_tready),
    .m_axis_video_tuser (m_axis_video_tuser),
    .m_axis_video_tlast (m_axis_video_tlast),
    .level              (level),
    .almost_full        (almost_full),
    .frame_err          (frame_err)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    rdy_mode = 0;
  beat_t exp_q[$];
  bit    m_synced;
  bit    m_prev_last;
  bit    err_next = 1'b0;
  bit    exp_err = 1'b0;
  int    err_expected = 0;
  int    err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
`ifdef FRAME_SYNC_EN
    m_synced = 1'b0;
`else
    m_synced = 1'b1;
`endif
    m_prev_last = 1'b1;
    err_next = 1'b0;
  endtask

  // Reference rules: error = SOF after a non-EOL beat (once synced); before sync only SOF beats are kept
  task automatic model_accept(input beat_t b);
    bit tu, tl;
    tu = b[DW+1];
    tl = b[DW];
    err_next = tu && !m_prev_last && m_synced;
    if (err_next) err_expected++;
    m_prev_last = tl;
    if (m_synced || tu) begin
      m_synced = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  // frame_err is expected one cycle after the accepting edge
  always @(posedge clk) exp_err <= err_next && reset;

  task automatic send(input beat_t b, input bit retry, output bit acc);
    int waited;
    waited = 0;
    acc = 1'b0;
    {s_axis_video_tuser, s_axis_video_tlast, s_axis_video_tdata} = b;
    s_axis_video_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_axis_video_tready) begin
        model_accept(b);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      err_next = 1'b0;
      if (acc || !retry) break;
      waited++;
      if (waited > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no ready expected ready within 200 cycles");
        break;
      end
    end
    s_axis_video_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h, input bit gaps);
    bit acc;
    for (int i = 0; i < w * h; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send({(i == 0), ((i % w) == w - 1), 24'($urandom)}, 1'b1, acc);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  // Output-ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_video_tready = 1'b0;
        1:       m_axis_video_tready = 1'b1;
        default: m_axis_video_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks hold-under-stall and frame_err
  initial begin
    beat_t got, held, want;
    bit stall;
    stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall = 1'b0;
        continue;
      end
      got = {m_axis_video_tuser, m_axis_video_tlast, m_axis_video_tdata};
      if (stall) begin
        check("hold_valid", m_axis_video_tvalid, 1);
        check("hold_data", got, held);
      end
      check("frame_err", frame_err, exp_err);
      if (frame_err) err_seen++;
      if (m_axis_video_tvalid && m_axis_video_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got 0x%0h expected no beat", got);
        end else begin
          want = exp_q.pop_front();
          check("beat", got, want);
        end
      end
      stall = m_axis_video_tvalid && !m_axis_video_tready;
      held = got;
    end
  end

  // Watchdog
  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got still running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    bit acc;
    int acc_n, lvl, e0, s0;
    beat_t b;
    model_reset();
    rdy_mode = 1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", s_axis_video_tready, 0);
    check("rst_m_tvalid", m_axis_video_tvalid, 0);
    check("rst_m_tdata", m_axis_video_tdata, 0);
    check("rst_m_tuser", m_axis_video_tuser, 0);
    check("rst_m_tlast", m_axis_video_tlast, 0);
    check("rst_level", level, 0);
    check("rst_afull", almost_full, 0);
    check("rst_frame_err", frame_err, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", s_axis_video_tready, 1);
    @(posedge clk);
    #1;

    // Single beat latency
    send({1'b1, 1'b0, 24'h123456}, 1'b1, acc);
    check("single_acc", acc, 1);
    @(negedge clk);
    check("lat_n1_valid", m_axis_video_tvalid, 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_n2_valid", m_axis_video_tvalid, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("single_level", level, 0);
    @(posedge clk);
    #1;

    // Fill and stall
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    acc_n = 0;
    for (int i = 0; i < 20; i++) begin
      b = {1'b0, ((i % 4) == 3), 24'($urandom)};
      {s_axis_video_tuser, s_axis_video_tlast, s_axis_video_tdata} = b;
      s_axis_video_tvalid = 1'b1;
      @(negedge clk);
      lvl = (acc_n <= 1) ? acc_n : acc_n - 1;
      check("fill_level", level, lvl);
      check("fill_afull", almost_full, (lvl >= 12));
      check("fill_ready", s_axis_video_tready, (acc_n < 17));
      if (s_axis_video_tready) begin
        model_accept(b);
        acc_n++;
      end
      @(posedge clk);
      #1;
      err_next = 1'b0;
    end
    s_axis_video_tvalid = 1'b0;
    @(negedge clk);
    check("fill_accepted", acc_n, 17);
    check("fill_full_level", level, 16);
    check("fill_full_ready", s_axis_video_tready, 0);
    check("fill_full_afull", almost_full, 1);
    rdy_mode = 1;
    drain("fill_drain");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("fill_end_level", level, 0);
    check("fill_end_valid", m_axis_video_tvalid, 0);
    @(posedge clk);
    #1;

    // Streaming frames with random gaps on both sides
    rdy_mode = 2;
    for (int f = 0; f < 3; f++) send_frame(4, 4, 1'b1);
    drain("stream_drain");

    // Framing error: SOF on the third beat of a line
    e0 = err_expected;
    s0 = err_seen;
    send({1'b0, 1'b0, 24'($urandom)}, 1'b1, acc);
    send({1'b0, 1'b0, 24'($urandom)}, 1'b1, acc);
    send({1'b1, 1'b0, 24'($urandom)}, 1'b1, acc);
    for (int j = 1; j < 16; j++) send({1'b0, ((j % 4) == 3), 24'($urandom)}, 1'b1, acc);
    drain("ferr_drain");
    repeat (2) @(posedge clk);
    #1;
    check("ferr_count", err_seen - s0, err_expected - e0);
    check("ferr_model_once", err_expected - e0, 1);

    // Reset mid-frame with beats buffered
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send({(i == 0), ((i % 4) == 3), 24'($urandom)}, 1'b1, acc);
    reset = 1'b0;
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", m_axis_video_tvalid, 0);
    check("midrst_level", level, 0);
    @(posedge clk);
    #1;
    rdy_mode = 2;
    send_frame(4, 4, 1'b1);
    drain("midrst_drain");

`ifdef FRAME_SYNC_EN
    // Start-up re-sync: beats before the first SOF are dropped but still accepted
    reset = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    rdy_mode = 1;
    for (int i = 0; i < 3; i++) begin
      send({1'b0, 1'b0, 24'($urandom)}, 1'b1, acc);
      check("sync_drop_acc", acc, 1);
    end
    send_frame(4, 4, 1'b0);
    drain("sync_drain");
`endif

    repeat (4) @(posedge clk);
    #1;
    check("final_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
